arb_requester: RTL and testbench

- Request side of the N-way arbiter. Turns per-channel job pulses from clients into arbiter requests.
- Holds each request until granted, keeps ownership for a fixed tenure, then releases so the arbiter can rotate.
- Sits between client logic and the arbiter. Its req vector drives the arbiter request input; the arbiter grant vector feeds back into gnt.

---
 rtl/arb_requester.sv | 144 ++++++++++++++
 tb/tb_arb_requester.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arb_requester.sv
// arb_requester: per-channel request FSMs that queue client jobs, hold req until granted,
// own the resource for HOLD cycles, then release. Optional grant-wait watchdog: ARB_REQ_TIMEOUT_EN.
module arb_requester #(
    parameter int N       = 4,
    parameter int HOLD    = 4,
    parameter int CNTW    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      job_in,
    input  logic [N-1:0]      gnt,
    output logic [N-1:0]      req,
    output logic [N-1:0]      busy,
    output logic [N-1:0]      done,
    output logic [N*CNTW-1:0] pending,
    output logic [N-1:0]      overflow,
    output logic [N-1:0]      timeout
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam int              TW    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [TW-1:0]   TLOAD = TW'(HOLD - 1);
    localparam logic [CNTW-1:0] PMAX  = {CNTW{1'b1}};

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t          state_r, state_s;
        logic [TW-1:0]   tcnt_r, tcnt_s;
        logic [CNTW-1:0] pend_r, pend_s;
        logic            ovf_s;
        logic            req_r, busy_r, done_r, ovf_r;

        // Channel FSM next state and tenure countdown; a dropped grant in OWN falls back to REQ
        always_comb begin
            state_s = state_r;
            tcnt_s  = tcnt_r;
            case (state_r)
                IDLE: begin
                    if (pend_r != '0) state_s = REQ;
                    else              state_s = IDLE;
                end
                REQ: begin
                    if (gnt[i]) begin
                        state_s = OWN;
                        tcnt_s  = TLOAD;
                    end else begin
                        state_s = REQ;
                    end
                end
                OWN: begin
                    if (!gnt[i])            state_s = REQ;
                    else if (tcnt_r == '0)  state_s = REL;
                    else                    tcnt_s  = tcnt_r - TW'(1);
                end
                REL:     state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end

        // Pending-job counter: a job arriving in REL cancels that cycle's decrement
        always_comb begin
            pend_s = pend_r;
            ovf_s  = 1'b0;
            if (job_in[i] && (state_r == REL)) begin
                pend_s = pend_r;
            end else if (job_in[i]) begin
                if (pend_r == PMAX) ovf_s  = 1'b1;
                else                pend_s = pend_r + CNTW'(1);
            end else if (state_r == REL) begin
                pend_s = pend_r - CNTW'(1);
            end else begin
                pend_s = pend_r;
            end
        end

        // State, counters and outputs, all decoded from the next state so they are registered
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_r <= IDLE;
                tcnt_r  <= '0;
                pend_r  <= '0;
                req_r   <= 1'b0;
                busy_r  <= 1'b0;
                done_r  <= 1'b0;
                ovf_r   <= 1'b0;
            end else begin
                state_r <= state_s;
                tcnt_r  <= tcnt_s;
                pend_r  <= pend_s;
                req_r   <= (state_s == REQ) || (state_s == OWN);
                busy_r  <= (state_s == OWN);
                done_r  <= (state_s == REL);
                ovf_r   <= ovf_r | ovf_s;
            end
        end

        assign req[i]                   = req_r;
        assign busy[i]                  = busy_r;
        assign done[i]                  = done_r;
        assign overflow[i]              = ovf_r;
        assign pending[i*CNTW +: CNTW]  = pend_r;

`ifdef ARB_REQ_TIMEOUT_EN
        localparam int WW = $clog2(TIMEOUT + 1);
        logic [WW-1:0] wcnt_r, wcnt_s;
        logic          tout_r, tout_s;

        // Grant-wait watchdog: counts ungranted REQ cycles, saturates at the limit
        always_comb begin
            wcnt_s = wcnt_r;
            tout_s = tout_r;
            if (state_r != REQ) begin
                wcnt_s = '0;
            end else if (gnt[i] || (wcnt_r == WW'(TIMEOUT))) begin
                wcnt_s = wcnt_r;
            end else begin
                wcnt_s = wcnt_r + WW'(1);
                if (wcnt_r == WW'(TIMEOUT - 1)) tout_s = 1'b1;
                else                            tout_s = tout_r;
            end
        end

        // Watchdog registers; the flag is sticky until reset
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wcnt_r <= '0;
                tout_r <= 1'b0;
            end else begin
                wcnt_r <= wcnt_s;
                tout_r <= tout_s;
            end
        end

        assign timeout[i] = tout_r;
`else
        assign timeout[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: table-driven vectors through a scoreboard queue,
// plus directed sequences for reset, competition, saturation and the grant-wait watchdog.
module tb_arb_requester;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  job_in, gnt;
    logic [3:0]  req, busy, done, overflow, timeout;
    logic [15:0] pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arb_requester #(.N(4), .HOLD(4), .CNTW(4), .TIMEOUT(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .job_in   (job_in),
        .gnt      (gnt),
        .req      (req),
        .busy     (busy),
        .done     (done),
        .pending  (pending),
        .overflow (overflow),
        .timeout  (timeout)
    );

    typedef struct {
        logic [3:0]  job;
        logic [3:0]  g;
        logic [3:0]  e_req;
        logic [3:0]  e_busy;
        logic [3:0]  e_done;
        logic [15:0] e_pend;
    } vec_t;

    typedef struct {
        int          idx;
        logic [3:0]  e_req;
        logic [3:0]  e_busy;
        logic [3:0]  e_done;
        logic [15:0] e_pend;
    } exp_t;

    vec_t tbl [0:28];
    exp_t sb [$];
    int   ord_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        job_in = 4'h0;
        gnt    = 4'h0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic [3:0] j, input logic [3:0] g,
                           input logic [3:0] r, input logic [3:0] b, input logic [3:0] d,
                           input logic [15:0] p);
        tbl[i].job    = j;
        tbl[i].g      = g;
        tbl[i].e_req  = r;
        tbl[i].e_busy = b;
        tbl[i].e_done = d;
        tbl[i].e_pend = p;
    endtask

    initial begin
        exp_t e;
        int   nd, owner, last, multi, fall_bad, eo;
        logic [3:0] prev_req;

        // ch2 single job, HOLD=4: grant -> done after 5 cycles, 2 low req cycles after
        set_vec( 0, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0100);
        set_vec( 1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 16'h0100);
        set_vec( 2, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 16'h0100);
        set_vec( 3, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 16'h0100);
        set_vec( 4, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 16'h0100);
        set_vec( 5, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 16'h0100);
        set_vec( 6, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4, 16'h0100);
        set_vec( 7, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        set_vec( 8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        // ch1: job in the REL cycle keeps pending at 1, then a grant lost in OWN
        set_vec( 9, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0010);
        set_vec(10, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 16'h0010);
        set_vec(11, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(12, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(13, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(14, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(15, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 16'h0010);
        set_vec(16, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0010);
        set_vec(17, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 16'h0010);
        set_vec(18, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(19, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(20, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 16'h0010);
        set_vec(21, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0, 16'h0010);
        set_vec(22, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(23, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(24, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(25, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 16'h0010);
        set_vec(26, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2, 16'h0010);
        set_vec(27, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        set_vec(28, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);

        rst    = 1'b1;
        job_in = 4'h0;
        gnt    = 4'h0;
        cyc();
        check("reset_flags", {16'h0, req, busy, done, overflow}, 32'h0);
        check("reset_pending", {16'h0, pending}, 32'h0);
        check("reset_timeout", {28'h0, timeout}, 32'h0);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            job_in = tbl[i].job;
            gnt    = tbl[i].g;
            e.idx    = i;
            e.e_req  = tbl[i].e_req;
            e.e_busy = tbl[i].e_busy;
            e.e_done = tbl[i].e_done;
            e.e_pend = tbl[i].e_pend;
            sb.push_back(e);
            cyc();
            e = sb.pop_front();
            check($sformatf("vec%0d", e.idx), {req, busy, done, pending[11:0], 8'h0},
                  {e.e_req, e.e_busy, e.e_done, e.e_pend[11:0], 8'h0});
        end
        check("table_overflow", {28'h0, overflow}, 32'h0);

        // round-robin arbiter model granting one channel at a time
        do_reset();
        for (int k = 0; k < 4; k++) ord_q.push_back(k);
        job_in = 4'hF;
        cyc();
        job_in   = 4'h0;
        nd       = 0;
        owner    = -1;
        last     = 3;
        multi    = 0;
        fall_bad = 0;
        prev_req = req;
        for (int c = 0; c < 80 && nd < 4; c++) begin
            if ($countones(busy) > 1) multi++;
            for (int ch = 0; ch < 4; ch++) begin
                if (done[ch]) begin
                    if (ord_q.size() == 0) begin
                        check("rr_extra_done", ch, 32'hFFFF);
                    end else begin
                        eo = ord_q.pop_front();
                        check("rr_done_order", ch, eo);
                    end
                    nd++;
                end
                if (prev_req[ch] && !req[ch] && !done[ch]) fall_bad++;
            end
            prev_req = req;
            if (owner >= 0 && !req[owner]) owner = -1;
            if (owner < 0) begin
                for (int k = 1; k <= 4; k++) begin
                    if (owner < 0 && req[(last + k) % 4]) owner = (last + k) % 4;
                end
                if (owner >= 0) last = owner;
            end
            gnt = 4'h0;
            if (owner >= 0) gnt[owner] = 1'b1;
            cyc();
        end
        gnt = 4'h0;
        check("rr_done_count", nd, 4);
        check("rr_one_busy", multi, 0);
        check("rr_req_falls_with_done", fall_bad, 0);
        cyc();
        check("rr_idle_after", {req, busy, pending[15:0], 8'h0}, 32'h0);

        // asynchronous reset in the middle of a ch0 tenure
        do_reset();
        job_in = 4'h1;
        cyc();
        cyc();
        job_in = 4'h0;
        gnt    = 4'h1;
        cyc();
        cyc();
        check("mid_busy0", busy[0], 1);
        check("mid_pending0", pending[3:0], 4'd2);
        #3 rst = 1'b1;
        #1;
        check("async_rst_flags", {16'h0, req, busy, done, overflow}, 32'h0);
        check("async_rst_pending", {16'h0, pending}, 32'h0);
        gnt = 4'h0;
        cyc();
        rst = 1'b0;

        // saturation on ch2/ch3, then a REL-cycle job at saturation on ch2
        do_reset();
        for (int k = 0; k < 15; k++) begin
            job_in = 4'hC;
            cyc();
        end
        job_in = 4'h0;
        check("sat_pending", pending[15:8], 8'hFF);
        check("sat_no_ovf_yet", {28'h0, overflow}, 32'h0);
        gnt = 4'h4;
        for (int k = 0; k < 5; k++) cyc();
        check("sat_rel_done2", done[2], 1);
        job_in = 4'h4;
        gnt    = 4'h0;
        cyc();
        check("sat_rel_pending2", pending[11:8], 4'd15);
        check("sat_rel_no_ovf2", overflow[2], 0);
        job_in = 4'h8;
        cyc();
        job_in = 4'h0;
        check("sat_pending3", pending[15:12], 4'd15);
        check("sat_ovf", {28'h0, overflow}, 32'h8);

        // grant-wait watchdog on ch0
        do_reset();
        job_in = 4'h1;
        cyc();
        job_in = 4'h0;
        cyc();
        check("to_req_entry", req[0], 1);
        for (int k = 0; k < 15; k++) cyc();
`ifdef ARB_REQ_TIMEOUT_EN
        check("to_before_limit", timeout[0], 0);
        cyc();
        check("to_at_limit", {28'h0, timeout}, 32'h1);
`else
        cyc();
        check("to_disabled", {28'h0, timeout}, 32'h0);
`endif
        gnt = 4'h1;
        nd  = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (done[0]) nd++;
        end
        gnt = 4'h0;
        check("to_grant_done", nd, 1);
        check("to_pending_clear", pending[3:0], 4'd0);
`ifdef ARB_REQ_TIMEOUT_EN
        check("to_sticky", timeout[0], 1);
`else
        check("to_still_zero", {28'h0, timeout}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
